// File: rtl/sp_ram_arb_pkg.sv
// Shared definitions for the two-master single-port RAM arbiter.
// Holds the controller state encoding and the number of masters.
package sp_ram_arb_pkg;

    localparam int NUM_MASTERS = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant plus a one-bit
// priority pointer that always moves to the master that was not just served.
module rr_arb2
    import sp_ram_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   en,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt
);

    // prio_q = 0 favours master 0 on a tie, 1 favours master 1.
    logic prio_q;

    always_comb begin
        gnt = '0;
        if (en) begin
            if (req[0] && (!req[1] || !prio_q)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between two masters with round-robin arbitration,
// optionally zero-filling the RAM after reset before any master is served.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b0,
    localparam int BE_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_i,

    // Handshake: a master holds mN_req_i and its attributes stable until it
    // sees mN_gnt_o high in the same cycle; the access is accepted on that
    // rising edge and mN_rvalid_o/mN_rdata_o answer exactly one cycle later.
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic                  m0_we_i,
    input  logic [BE_WIDTH-1:0]   m0_be_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic                  m1_we_i,
    input  logic [BE_WIDTH-1:0]   m1_be_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  ram_we_o,
    output logic [BE_WIDTH-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,

    output logic                  init_done_o,
    output logic                  dbg_state_o
);

    localparam int BYTE_BITS = $clog2(BE_WIDTH);
    localparam int WORD_BITS = ADDR_WIDTH - BYTE_BITS;

    arb_state_e                 state_q, state_d;
    logic [WORD_BITS-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0]     req, gnt, rvalid_q;

    assign req = {m1_req_i, m0_req_i};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_i (rst_i),
        .en    ((state_q == RUN) && !rst_i),
        .req   (req),
        .gnt   (gnt)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        case (state_q)
            CLEAR: begin
                // The counter wraps to 0 naturally on the last word.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {WORD_BITS{1'b1}}) begin
                    state_d = RUN;
                end
                if (!rst_i) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_be_o   = '1;
                    ram_addr_o = ADDR_WIDTH'(cnt_q) << BYTE_BITS;
                end
            end
            RUN: begin
                if (gnt[0]) begin
                    ram_en_o    = 1'b1;
                    ram_addr_o  = m0_addr_i;
                    ram_wdata_o = m0_wdata_i;
                    ram_we_o    = m0_we_i;
                    ram_be_o    = m0_be_i;
                end else if (gnt[1]) begin
                    ram_en_o    = 1'b1;
                    ram_addr_o  = m1_addr_i;
                    ram_wdata_o = m1_wdata_i;
                    ram_we_o    = m1_we_i;
                    ram_be_o    = m1_be_i;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= CLEAR_ON_RESET ? CLEAR : RUN;
            cnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= gnt;
        end
    end

    // A reset arriving while a response is pending suppresses it immediately.
    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid_q[0] && !rst_i;
    assign m1_rvalid_o = rvalid_q[1] && !rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
    assign init_done_o = (state_q == RUN);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with RAM clearing enabled
// and a 64-byte RAM behind it.
module tb_sp_ram_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst_i;
    logic          m0_req, m1_req, m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [BW-1:0] m0_be, m1_be;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [BW-1:0] ram_be;
    logic          init_done, dbg_state;

    int compared = 0;
    int mismatched = 0;

    sp_ram_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .m0_req_i    (m0_req),
        .m0_addr_i   (m0_addr),
        .m0_wdata_i  (m0_wdata),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_gnt_o    (m0_gnt),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_addr_i   (m1_addr),
        .m1_wdata_i  (m1_wdata),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_gnt_o    (m1_gnt),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_rdata),
        .init_done_o (init_done),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: byte-enabled write, read data one cycle later.
    logic [DW-1:0] mem [0:(1<<AW)/BW-1];
    initial begin
        for (int i = 0; i < (1<<AW)/BW; i++) mem[i] = 32'hFFFF_FFFF;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[AW-1:2]];
            if (ram_we) begin
                for (int b = 0; b < BW; b++) begin
                    if (ram_be[b]) mem[ram_addr[AW-1:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic drive_m0(input logic req, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic we, input logic [BW-1:0] be);
        m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_we = we; m0_be = be;
    endtask

    task automatic drive_m1(input logic req, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic we, input logic [BW-1:0] be);
        m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_we = we; m1_be = be;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        drive_m1(1'b0, '0, '0, 1'b0, '0);
        next_cycle();
        next_cycle();

        // Reset state, with a request pending that must not be granted
        drive_m0(1'b1, 6'h10, '0, 1'b0, 4'hF);
        settle();
        check("rst_init_done", init_done, 0);
        check("rst_dbg_state", dbg_state, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_be", ram_be, 0);
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m0_rdata", m0_rdata, 0);
        next_cycle();

        // Zero-fill sequence: 16 words, no grants while clearing
        rst_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            check($sformatf("clr%0d_en", k), ram_en, 1);
            check($sformatf("clr%0d_we", k), ram_we, 1);
            check($sformatf("clr%0d_addr", k), ram_addr, 64'(k * 4));
            check($sformatf("clr%0d_wdata", k), ram_wdata, 0);
            check($sformatf("clr%0d_be", k), ram_be, 4'hF);
            check($sformatf("clr%0d_gnt", k), m0_gnt, 0);
            check($sformatf("clr%0d_done", k), init_done, 0);
            next_cycle();
        end
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        settle();
        check("clr_done", init_done, 1);
        check("clr_dbg_state", dbg_state, 1);
        check("idle_ram_en", ram_en, 0);
        check("idle_m0_rvalid", m0_rvalid, 0);
        next_cycle();

        // m0 writes 0xDEADBEEF to 0x10, then reads it back alone
        drive_m0(1'b1, 6'h10, 32'hDEAD_BEEF, 1'b1, 4'hF);
        settle();
        check("wr10_m0_gnt", m0_gnt, 1);
        check("wr10_m1_gnt", m1_gnt, 0);
        check("wr10_ram_en", ram_en, 1);
        check("wr10_ram_we", ram_we, 1);
        check("wr10_ram_addr", ram_addr, 6'h10);
        check("wr10_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        next_cycle();
        drive_m0(1'b1, 6'h10, '0, 1'b0, 4'hF);
        settle();
        check("rd10_m0_gnt", m0_gnt, 1);
        check("rd10_ram_we", ram_we, 0);
        check("wr10_m0_rvalid", m0_rvalid, 1);
        next_cycle();
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        settle();
        check("rd10_m0_rvalid", m0_rvalid, 1);
        check("rd10_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd10_m1_rvalid", m1_rvalid, 0);
        check("rd10_m1_rdata", m1_rdata, 0);
        check("rd10_idle_en", ram_en, 0);
        check("rd10_idle_addr", ram_addr, 0);
        next_cycle();

        // Partial write by m1 over a full word written by m0
        drive_m0(1'b1, 6'h20, 32'h1234_5678, 1'b1, 4'hF);
        settle();
        check("wr20_m0_gnt", m0_gnt, 1);
        next_cycle();
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        drive_m1(1'b1, 6'h20, 32'hA5A5_A5A5, 1'b1, 4'b0011);
        settle();
        check("pw20_m1_gnt", m1_gnt, 1);
        check("pw20_m0_gnt", m0_gnt, 0);
        check("pw20_ram_be", ram_be, 4'b0011);
        check("pw20_ram_addr", ram_addr, 6'h20);
        check("pw20_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
        next_cycle();
        drive_m1(1'b0, '0, '0, 1'b0, '0);
        drive_m0(1'b1, 6'h20, '0, 1'b0, 4'hF);
        settle();
        check("pw20_m1_rvalid", m1_rvalid, 1);
        check("rd20_m0_gnt", m0_gnt, 1);
        next_cycle();
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        settle();
        check("rd20_m0_rvalid", m0_rvalid, 1);
        check("rd20_m0_rdata", m0_rdata, 32'h1234_A5A5);
        next_cycle();

        // Reset the cycle after a granted read: the response is dropped
        drive_m0(1'b1, 6'h10, '0, 1'b0, 4'hF);
        settle();
        check("abort_m0_gnt", m0_gnt, 1);
        next_cycle();
        rst_i = 1'b1;
        settle();
        check("abort_m0_rvalid", m0_rvalid, 0);
        check("abort_m0_rdata", m0_rdata, 0);
        check("abort_m0_gnt_rst", m0_gnt, 0);
        check("abort_ram_en", ram_en, 0);
        next_cycle();
        rst_i = 1'b0;
        drive_m0(1'b0, '0, '0, 1'b0, '0);

        // Clear restarts; a reset pulse at word 7 restarts it from word 0
        for (int k = 0; k < 7; k++) begin
            settle();
            check($sformatf("reclr%0d_addr", k), ram_addr, 64'(k * 4));
            check($sformatf("reclr%0d_rvalid", k), m0_rvalid, 0);
            next_cycle();
        end
        rst_i = 1'b1;
        settle();
        check("reclr7_rst_en", ram_en, 0);
        check("reclr7_rst_done", init_done, 0);
        next_cycle();
        rst_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            check($sformatf("clr2_%0d_en", k), ram_en, 1);
            check($sformatf("clr2_%0d_addr", k), ram_addr, 64'(k * 4));
            check($sformatf("clr2_%0d_rvalid", k), m0_rvalid, 0);
            next_cycle();
        end

        // Both masters request every cycle: grants alternate m0, m1, m0, m1
        drive_m0(1'b1, 6'h04, '0, 1'b0, 4'hF);
        drive_m1(1'b1, 6'h08, '0, 1'b0, 4'hF);
        settle();
        check("rr0_done", init_done, 1);
        check("rr0_m0_gnt", m0_gnt, 1);
        check("rr0_m1_gnt", m1_gnt, 0);
        check("rr0_addr", ram_addr, 6'h04);
        next_cycle();
        settle();
        check("rr1_m0_gnt", m0_gnt, 0);
        check("rr1_m1_gnt", m1_gnt, 1);
        check("rr1_addr", ram_addr, 6'h08);
        check("rr1_m0_rvalid", m0_rvalid, 1);
        check("rr1_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        settle();
        check("rr2_m0_gnt", m0_gnt, 1);
        check("rr2_m1_gnt", m1_gnt, 0);
        check("rr2_m0_rvalid", m0_rvalid, 0);
        check("rr2_m1_rvalid", m1_rvalid, 1);
        check("rr2_m1_rdata", m1_rdata, 0);
        next_cycle();
        settle();
        check("rr3_m0_gnt", m0_gnt, 0);
        check("rr3_m1_gnt", m1_gnt, 1);
        check("rr3_m0_rvalid", m0_rvalid, 1);
        check("rr3_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        drive_m0(1'b0, '0, '0, 1'b0, '0);
        drive_m1(1'b0, '0, '0, 1'b0, '0);
        settle();
        check("rr4_m1_rvalid", m1_rvalid, 1);
        check("rr4_m0_rvalid", m0_rvalid, 0);
        check("rr4_ram_en", ram_en, 0);
        check("rr4_ram_we", ram_we, 0);
        next_cycle();

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
